// File: rtl/e_mdu_if.sv
// D->E operand/op bundle into the multiply/divide unit and its
// HI/LO, busy and mfhi/mflo read-back outputs.
interface e_mdu_if;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_start;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] mdu_rd;

    modport master (
        output md_op, rs_val, rt_val,
        input  md_start, busy, hi_out, lo_out, mdu_rd
    );

    modport slave (
        input  md_op, rs_val, rt_val,
        output md_start, busy, hi_out, lo_out, mdu_rd
    );
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: architectural HI/LO with a
// fixed-latency busy window before each mult/div result commits.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic   clk,
    input logic   reset,
    e_mdu_if.slave md
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic [CW-1:0] cnt;
    logic          busy_q;
    logic [31:0]   hi_q, lo_q;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_dz;

    logic          is_mult, is_multu, is_div, is_divu;
    logic          is_md, start;
    logic [31:0]   rs, rt;
    logic [63:0]   mul_s, mul_u;
    logic [31:0]   q_s, r_s, q_u, r_u;
    logic [31:0]   res_hi, res_lo;

    assign rs       = md.rs_val;
    assign rt       = md.rt_val;
    assign is_mult  = md.md_op == OP_MULT;
    assign is_multu = md.md_op == OP_MULTU;
    assign is_div   = md.md_op == OP_DIV;
    assign is_divu  = md.md_op == OP_DIVU;
    assign is_md    = is_mult | is_multu | is_div | is_divu;
    assign start    = is_md & ~busy_q;

    // 64-bit operands so the low 64 bits give the exact product
    assign mul_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign mul_u = {32'b0, rs} * {32'b0, rt};

    always_comb begin
        q_s = '0;
        r_s = '0;
        q_u = '0;
        r_u = '0;
        if (rt != 32'd0) begin
            q_u = rs / rt;
            r_u = rs % rt;
            if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
                q_s = 32'h8000_0000;
                r_s = 32'd0;
            end else begin
                q_s = $signed(rs) / $signed(rt);
                r_s = $signed(rs) % $signed(rt);
            end
        end
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        unique case (1'b1)
            is_mult:  {res_hi, res_lo} = mul_s;
            is_multu: {res_hi, res_lo} = mul_u;
            is_div:   begin res_hi = r_s; res_lo = q_s; end
            is_divu:  begin res_hi = r_u; res_lo = q_u; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_dz <= 1'b0;
        end else if (start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_dz <= (is_div | is_divu) & (rt == 32'd0);
            cnt     <= (is_mult | is_multu) ?
                       CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy_q <= 1'b0;
                if (!pend_dz) begin
                    hi_q <= pend_hi;
                    lo_q <= pend_lo;
                end
            end
        end else begin
            if (md.md_op == OP_MTHI) hi_q <= rs;
            if (md.md_op == OP_MTLO) lo_q <= rs;
        end
    end

    assign md.md_start = start;
    assign md.busy     = busy_q;
    assign md.hi_out   = hi_q;
    assign md.lo_out   = lo_q;
    assign md.mdu_rd   = (md.md_op == OP_MFHI) ? hi_q :
                         (md.md_op == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
// Randomized bench for e_mdu against a cycle-indexed HI/LO model
// computed with plain 64-bit arithmetic.
module tb_e_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    e_mdu_if md();

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk),
        .reset(reset),
        .md(md)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_v, p_dz;
    int          p_done;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%08h exp=%08h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic ref_op(input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l,
                          output bit dz);
        longint sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        h  = 32'd0;
        l  = 32'd0;
        dz = 1'b0;
        case (op)
            4'd1: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
            4'd2: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
            4'd3: begin
                dz = (b == 32'd0);
                if (!dz) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    h  = sr[31:0];
                    l  = sq[31:0];
                end
            end
            default: begin
                dz = (b == 32'd0);
                if (!dz) begin
                    up = ua % ub;
                    h  = up[31:0];
                    up = ua / ub;
                    l  = up[31:0];
                end
            end
        endcase
    endtask

    task automatic cycle(input bit rst, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        bit exp_start;
        logic [31:0] exp_rd;
        reset     = rst;
        md.md_op  = op;
        md.rs_val = a;
        md.rt_val = b;
        #1;
        exp_start = (op >= 4'd1 && op <= 4'd4 && !p_v);
        exp_rd    = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
        check("md_start", {31'b0, md.md_start}, {31'b0, exp_start});
        check("mdu_rd", md.mdu_rd, exp_rd);
        if (!rst && !p_v) begin
            if (op >= 4'd1 && op <= 4'd4) begin
                ref_op(op, a, b, p_hi, p_lo, p_dz);
                p_v    = 1'b1;
                p_done = cyc + ((op <= 4'd2) ? MC : DC) + 1;
            end else if (op == 4'd5) begin
                m_hi = a;
            end else if (op == 4'd6) begin
                m_lo = a;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            p_v  = 1'b0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else if (p_v && cyc == p_done) begin
            p_v = 1'b0;
            if (!p_dz) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end
        check("busy", {31'b0, md.busy}, {31'b0, p_v});
        check("hi_out", md.hi_out, m_hi);
        check("lo_out", md.lo_out, m_lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    logic [31:0] ra, rb;
    logic [3:0]  rop;

    initial begin
        reset     = 1'b1;
        md.md_op  = 4'd0;
        md.rs_val = 32'd0;
        md.rt_val = 32'd0;
        p_v = 1'b0; p_dz = 1'b0; p_done = 0;
        m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0;
        cycle(1'b1, 4'd0, 32'd0, 32'd0);
        cycle(1'b1, 4'd0, 32'd0, 32'd0);
        idle(2);
        cycle(1'b0, 4'd7, 32'd0, 32'd0);

        cycle(1'b0, 4'd1, 32'hFFFF_FFFD, 32'd7);
        idle(MC + 1);
        check("mult_hi", md.hi_out, 32'hFFFF_FFFF);
        check("mult_lo", md.lo_out, 32'hFFFF_FFEB);

        cycle(1'b0, 4'd2, 32'hFFFF_FFFF, 32'd2);
        idle(MC + 1);
        check("multu_hi", md.hi_out, 32'h0000_0001);
        check("multu_lo", md.lo_out, 32'hFFFF_FFFE);

        cycle(1'b0, 4'd3, 32'hFFFF_FFF9, 32'd2);
        idle(DC + 1);
        check("div_hi", md.hi_out, 32'hFFFF_FFFF);
        check("div_lo", md.lo_out, 32'hFFFF_FFFD);

        cycle(1'b0, 4'd4, 32'd7, 32'd0);
        idle(DC + 1);
        check("divz_hi", md.hi_out, 32'hFFFF_FFFF);
        check("divz_lo", md.lo_out, 32'hFFFF_FFFD);

        cycle(1'b0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DC + 1);
        check("ovf_hi", md.hi_out, 32'h0000_0000);
        check("ovf_lo", md.lo_out, 32'h8000_0000);

        cycle(1'b0, 4'd1, 32'd6, 32'd9);
        cycle(1'b0, 4'd5, 32'h1234, 32'd0);
        cycle(1'b0, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cycle(1'b0, 4'd7, 32'd0, 32'd0);
        idle(MC - 4);
        cycle(1'b0, 4'd6, 32'hDEAD, 32'd0);
        idle(1);
        check("busy_ign_hi", md.hi_out, 32'd0);
        check("busy_ign_lo", md.lo_out, 32'd54);
        cycle(1'b0, 4'd5, 32'h1234, 32'd0);
        cycle(1'b0, 4'd7, 32'd0, 32'd0);
        check("mthi_hi", md.hi_out, 32'h0000_1234);

        cycle(1'b0, 4'd3, 32'd100, 32'd7);
        idle(3);
        cycle(1'b1, 4'd0, 32'd0, 32'd0);
        idle(DC + 2);
        check("rst_hi", md.hi_out, 32'd0);
        check("rst_lo", md.lo_out, 32'd0);

        for (int i = 0; i < 400; i++) begin
            rop = 4'($urandom_range(0, 8));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                3: ra = 32'($signed(-$urandom_range(1, 99)));
                default: ;
            endcase
            cycle(($urandom_range(0, 99) == 0), rop, ra, rb);
        end
        idle(DC + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
